stream_fifo: RTL

- Parametrised synchronous FIFO with valid/ready handshakes on both sides, for buffering AXI4 channel payloads (AW/W/AR/R/B) inside the crossbar and its test environment.
- Next generation of the team's pointer-based queue:
  - all 2^ADDR_W entries are usable, using extra-bit pointers;
  - occupancy count, programmable almost-full and almost-empty flags, synchronous flush, and a high-water mark.
- Sits between a producer and a consumer; it never drops or duplicates a beat.

---
 rtl/stream_fifo_pkg.sv | 49 ++++
 rtl/stream_fifo_ram.sv | 30 +++
 rtl/stream_fifo.sv | 91 +++++++++
 3 files changed

// File: rtl/stream_fifo_pkg.sv
// Shared definitions for stream_fifo and its users.
//   fifo_depth() : number of entries for a given address width.
//   occupancy()  : entry count from two extra-bit pointers, modulo 2^(addr_w+1).
//   *_beat_t     : AXI4 channel payloads; crossbar instances set WIDTH = $bits(...).
package stream_fifo_pkg;

  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  // Pointers are zero-extended to 32 bits by the caller. The mask restores
  // the natural wrap of an (addr_w+1)-bit subtraction.
  function automatic logic [31:0] occupancy(input logic [31:0] wr,
                                            input logic [31:0] rd,
                                            input int unsigned addr_w);
    logic [31:0] mask;
    mask = (32'd1 << (addr_w + 1)) - 32'd1;
    return (wr - rd) & mask;
  endfunction

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } aw_beat_t;

  typedef aw_beat_t ar_beat_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_beat_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_beat_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_beat_t;

endpackage

// File: rtl/stream_fifo_ram.sv
// fifo_ram: DEPTH x WIDTH storage with one synchronous write port and one
// asynchronous read port. Kept separate so it can be swapped for a macro.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data, combinational from raddr
module fifo_ram #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stream_fifo.sv
// stream_fifo: synchronous valid/ready FIFO with all 2^ADDR_W entries usable,
// occupancy count, almost-full/almost-empty flags, flush and high-water mark.
//   clk, rstn      : clock, synchronous active-low reset
//   flush          : synchronous clear of pointers and high-water mark
//   in_valid/in_ready/in_data    : producer handshake; in_ready = !full
//   out_valid/out_ready/out_data : consumer handshake; out_valid = !empty,
//                                  out_data is first-word fall-through
//   count          : occupancy 0..DEPTH
//   almost_full    : count >= AF_LEVEL
//   almost_empty   : count <= AE_LEVEL
//   high_water     : maximum count since last reset or flush
module stream_fifo
  import stream_fifo_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 3,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [ADDR_W:0]   count,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   high_water
);

  localparam int PW    = ADDR_W + 1;
  localparam int DEPTH = fifo_depth(ADDR_W);
  localparam logic [ADDR_W:0] AF_THR = PW'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_THR = PW'(AE_LEVEL);

  logic [ADDR_W:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0] wr_ptr_next, rd_ptr_next;
  logic [ADDR_W:0] count_next;
  logic            full, empty, push, pop;

  // Status is derived only from registered pointers, so ready never depends
  // combinationally on out_ready and flags cannot glitch on input changes.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && !full;
  assign pop       = out_ready && !empty;

  assign count        = PW'(occupancy(32'(wr_ptr), 32'(rd_ptr), ADDR_W));
  assign almost_full  = (count >= AF_THR);
  assign almost_empty = (count <= AE_THR);

  assign wr_ptr_next = wr_ptr + PW'(push);
  assign rd_ptr_next = rd_ptr + PW'(pop);
  assign count_next  = PW'(occupancy(32'(wr_ptr_next), 32'(rd_ptr_next), ADDR_W));

  // Pointer / high-water register stage; reset outranks flush, flush
  // outranks any concurrent push or pop.
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      high_water <= '0;
    end else begin
      wr_ptr <= wr_ptr_next;
      rd_ptr <= rd_ptr_next;
      if (count_next > high_water) high_water <= count_next;
    end
  end

  fifo_ram #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push && rstn && !flush),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (in_data),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (out_data)
  );

endmodule
